charge_phase_sequencer: RTL and testbench
=========================================

# charge_phase_sequencer

Charge-phase controller for a single battery pack. It sequences the charger through trickle, bulk and taper phases from the monitored battery level and pack voltage, and enforces overcharge and taper-timeout faults. It drives the charger's enable and current-select inputs and sits alongside the battery health monitor, consuming the same `battery_level` / `voltage` measurements.

## Interface
- `TRICKLE_LEVEL`, 8'd20: below this level the sequencer charges at trickle current.
- `CV_LEVEL`, 8'd80: at or above this level the sequencer enters the taper phase.
- `FULL_LEVEL`, 8'd100: full-charge level; any level above it is a fault.
- `RESTART_LEVEL`, 8'd95: in DONE, a level below this restarts charging.
- `MAX_VOLTAGE`, 8'd240: any voltage strictly above this is an overvoltage fault.
- `QUAL_CYCLES`, 4: consecutive cycles a forward-progress condition must hold; range 1..15.
- `TAPER_TIMEOUT`, 16'd1000: maximum number of cycles allowed in TAPER.
- `clk` input 1: system clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `charger_present` input 1: charger attached.
- `battery_level` input 8: battery level in percent.
- `voltage` input 8: pack voltage.
- `fault_clear` input 1: level-sensitive request to leave FAULT.
- `charge_en` output 1: charger enable.
- `current_sel` output 2: 0 = off, 1 = trickle, 2 = bulk, 3 = taper.
- `phase` output 3: current state encoding.
- `done` output 1: charge complete.
- `fault` output 1: in FAULT.
- `fault_code` output 2: 0 = none, 1 = overvoltage, 2 = overlevel, 3 = taper timeout.
- `phase_change` output 1: one-cycle pulse on every state change.

## Operation
- States and `phase` encoding: IDLE = 0, TRICKLE = 1, BULK = 2, TAPER = 3, DONE = 4, FAULT = 5. Encodings 6 and 7 recover to IDLE on the next edge.
- Outputs are a pure decode of registered state:
  - `charge_en` = 1 only in TRICKLE, BULK and TAPER.
  - `current_sel` = 1, 2, 3 in TRICKLE, BULK, TAPER respectively; 0 in all other states.
  - `done` = 1 only in DONE.
  - `fault` = 1 only in FAULT.
  - `fault_code` is latched on entry to FAULT, held while in FAULT, and is 0 in every other state.
- IDLE: with `charger_present` = 1, the next edge moves to one of these states, no qualification:
  - TRICKLE if level < `TRICKLE_LEVEL`.
  - BULK if level < `CV_LEVEL`.
  - TAPER if level < `FULL_LEVEL`.
  - DONE if level == `FULL_LEVEL`.
  - FAULT if the fault checks below fire.
  - With `charger_present` = 0, stay in IDLE.
- TRICKLE, BULK and TAPER (charging states) evaluate in strict priority each edge:
  1. voltage > `MAX_VOLTAGE` → FAULT, code 1.
  2. level > `FULL_LEVEL` → FAULT, code 2.
  3. `charger_present` = 0 → IDLE.
  4. Taper timeout → FAULT, code 3.
  5. Qualified progress: TRICKLE→BULK when level ≥ `TRICKLE_LEVEL`; BULK→TAPER when level ≥ `CV_LEVEL`; TAPER→DONE when level == `FULL_LEVEL`.
- Qualification counter (4-bit):
  - Increments each edge the current state's progress condition holds.
  - Clears when the condition is false and on every state change.
  - The transition is taken on the edge where the count would reach `QUAL_CYCLES`.
  - Faults and charger removal bypass qualification.
- Taper timer (16-bit):
  - Cleared on entry to TAPER; increments each cycle in TAPER, saturating.
  - After `TAPER_TIMEOUT` consecutive cycles in TAPER, the next edge enters FAULT code 3 unless a higher-priority transition applies.
- DONE:
  - Overvoltage or overlevel → FAULT, code 1 or 2.
  - `charger_present` = 0 → IDLE.
  - Level < `RESTART_LEVEL` held for `QUAL_CYCLES` → IDLE, which then re-enters charging.
- FAULT:
  - Exits to IDLE only on an edge where `fault_clear` = 1, voltage ≤ `MAX_VOLTAGE` and level ≤ `FULL_LEVEL`.
  - Otherwise stays in FAULT and keeps the original code, even if a different fault condition appears.
- `phase_change` is registered: it is 1 for exactly the cycle following any edge that changed state.

## Timing
- Reset values (on a reset edge): state IDLE; counters 0; `charge_en` 0, `current_sel` 0, `phase` 0, `done` 0, `fault` 0, `fault_code` 0, `phase_change` 0.
- Reset mid-charge forces IDLE and `charge_en` 0 on that same edge, with no `phase_change` pulse.
- Unqualified transitions: input sampled at edge N; state and outputs change immediately after edge N (1-cycle latency).
- Qualified transitions: the condition must be sampled true on `QUAL_CYCLES` consecutive edges; the state changes at the last of those edges. `QUAL_CYCLES` = 1 behaves as unqualified.
- Simultaneous overvoltage and overlevel → code 1.
- Fault together with charger removal → FAULT.
- Level crossing several thresholds in one cycle: only one state step per edge, and each new state requalifies from 0.
- `fault_clear` asserted outside FAULT is ignored.

## Test plan
- Ramp from empty: charger on, level 10 stepping +1 every 8 cycles to 100, voltage 200 → IDLE → TRICKLE (`current_sel` 1) → BULK at level 20 after 4 qualified cycles → TAPER at 80 → DONE at 100; `phase_change` pulses exactly 4 times.
- Overvoltage in BULK: voltage 241 for one cycle → FAULT code 1 on the next edge, `charge_en` 0. `fault_clear` with voltage still 241 → remains FAULT. Voltage 200 plus `fault_clear` → IDLE.
- Taper timeout: hold level 90 in TAPER with `TAPER_TIMEOUT` = 1000 → FAULT code 3 exactly 1000 cycles after TAPER entry.
- Glitch rejection: in TRICKLE, level 20 for 3 cycles, then 19, then 20 for 4 cycles → BULK only after the final 4-cycle run.
- Charger removal and restart: remove charger in TAPER → IDLE next edge. In DONE, level drops to 94 for 4 cycles → IDLE then TAPER.
- Reset mid-TAPER and simultaneous faults: reset → all outputs 0. Level 101 with voltage 250 → FAULT code 1.

Source files
------------

// File: rtl/charge_phase_sequencer.sv
// rtl/charge_phase_sequencer.sv - charge-phase controller: trickle/bulk/taper sequencing with fault latching
module charge_phase_sequencer #(
  parameter logic [7:0]  TRICKLE_LEVEL = 8'd20,
  parameter logic [7:0]  CV_LEVEL      = 8'd80,
  parameter logic [7:0]  FULL_LEVEL    = 8'd100,
  parameter logic [7:0]  RESTART_LEVEL = 8'd95,
  parameter logic [7:0]  MAX_VOLTAGE   = 8'd240,
  parameter int unsigned QUAL_CYCLES   = 4,
  parameter logic [15:0] TAPER_TIMEOUT = 16'd1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       charger_present,
  input  logic [7:0] battery_level,
  input  logic [7:0] voltage,
  input  logic       fault_clear,
  output logic       charge_en,
  output logic [1:0] current_sel,
  output logic [2:0] phase,
  output logic       done,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic       phase_change
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRICKLE = 3'd1,
    ST_BULK    = 3'd2,
    ST_TAPER   = 3'd3,
    ST_DONE    = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

  // Transition fires on the edge where the count would reach QUAL_CYCLES.
  localparam logic [3:0]  QUAL_LAST  = 4'(QUAL_CYCLES - 1);
  // Timeout fires on the edge that completes TAPER_TIMEOUT cycles in TAPER.
  localparam logic [15:0] TAPER_LAST = TAPER_TIMEOUT - 16'd1;

  localparam logic [1:0] CODE_NONE  = 2'd0;
  localparam logic [1:0] CODE_OVERV = 2'd1;
  localparam logic [1:0] CODE_OVERL = 2'd2;
  localparam logic [1:0] CODE_TAPER = 2'd3;

  state_t      state_q;
  logic [3:0]  qual_cnt;
  logic [15:0] taper_cnt;

  state_t      nxt_state;
  logic [1:0]  nxt_code;
  logic [3:0]  nxt_qual;
  logic [15:0] nxt_taper;
  logic [1:0]  nxt_sel;
  logic        over_v;
  logic        over_l;
  logic        progress;
  logic        qual_done;
  logic        taper_expired;

  assign phase = state_q;

  // Next-state, fault-code and counter update from the current state and measurements.
  always_comb begin
    nxt_state     = state_q;
    nxt_code      = (state_q == ST_FAULT) ? fault_code : CODE_NONE;
    nxt_qual      = 4'd0;
    nxt_taper     = 16'd0;
    nxt_sel       = 2'd0;
    over_v        = voltage > MAX_VOLTAGE;
    over_l        = battery_level > FULL_LEVEL;
    taper_expired = (state_q == ST_TAPER) && (taper_cnt >= TAPER_LAST);

    case (state_q)
      ST_TRICKLE: progress = battery_level >= TRICKLE_LEVEL;
      ST_BULK:    progress = battery_level >= CV_LEVEL;
      ST_TAPER:   progress = battery_level == FULL_LEVEL;
      ST_DONE:    progress = battery_level < RESTART_LEVEL;
      default:    progress = 1'b0;
    endcase
    qual_done = progress && (qual_cnt >= QUAL_LAST);

    case (state_q)
      ST_IDLE: begin
        if (charger_present) begin
          if (over_v) begin
            nxt_state = ST_FAULT;
            nxt_code  = CODE_OVERV;
          end else if (over_l) begin
            nxt_state = ST_FAULT;
            nxt_code  = CODE_OVERL;
          end else if (battery_level < TRICKLE_LEVEL) begin
            nxt_state = ST_TRICKLE;
          end else if (battery_level < CV_LEVEL) begin
            nxt_state = ST_BULK;
          end else if (battery_level < FULL_LEVEL) begin
            nxt_state = ST_TAPER;
          end else begin
            nxt_state = ST_DONE;
          end
        end
      end
      ST_TRICKLE, ST_BULK, ST_TAPER, ST_DONE: begin
        if (over_v) begin
          nxt_state = ST_FAULT;
          nxt_code  = CODE_OVERV;
        end else if (over_l) begin
          nxt_state = ST_FAULT;
          nxt_code  = CODE_OVERL;
        end else if (!charger_present) begin
          nxt_state = ST_IDLE;
        end else if (taper_expired) begin
          nxt_state = ST_FAULT;
          nxt_code  = CODE_TAPER;
        end else if (qual_done) begin
          case (state_q)
            ST_TRICKLE: nxt_state = ST_BULK;
            ST_BULK:    nxt_state = ST_TAPER;
            ST_TAPER:   nxt_state = ST_DONE;
            default:    nxt_state = ST_IDLE;
          endcase
        end else if (progress) begin
          nxt_qual = qual_cnt + 4'd1;
        end
      end
      ST_FAULT: begin
        if (fault_clear && !over_v && !over_l) begin
          nxt_state = ST_IDLE;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase

    if (nxt_state != ST_FAULT) begin
      nxt_code = CODE_NONE;
    end

    // Taper timer runs only while staying in TAPER; entry starts it from zero.
    if (state_q == ST_TAPER && nxt_state == ST_TAPER) begin
      nxt_taper = (taper_cnt == 16'hFFFF) ? taper_cnt : taper_cnt + 16'd1;
    end

    case (nxt_state)
      ST_TRICKLE: nxt_sel = 2'd1;
      ST_BULK:    nxt_sel = 2'd2;
      ST_TAPER:   nxt_sel = 2'd3;
      default:    nxt_sel = 2'd0;
    endcase
  end

  // State, counters and decoded outputs all registered together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      qual_cnt     <= 4'd0;
      taper_cnt    <= 16'd0;
      charge_en    <= 1'b0;
      current_sel  <= 2'd0;
      done         <= 1'b0;
      fault        <= 1'b0;
      fault_code   <= CODE_NONE;
      phase_change <= 1'b0;
    end else begin
      state_q      <= nxt_state;
      qual_cnt     <= nxt_qual;
      taper_cnt    <= nxt_taper;
      charge_en    <= (nxt_state == ST_TRICKLE) || (nxt_state == ST_BULK) || (nxt_state == ST_TAPER);
      current_sel  <= nxt_sel;
      done         <= nxt_state == ST_DONE;
      fault        <= nxt_state == ST_FAULT;
      fault_code   <= nxt_code;
      phase_change <= nxt_state != state_q;
    end
  end

endmodule

// File: tb/tb_charge_phase_sequencer.sv
// tb/tb_charge_phase_sequencer.sv - directed self-checking bench for charge_phase_sequencer
module tb_charge_phase_sequencer;

  logic       clk;
  logic       reset;
  logic       charger_present;
  logic [7:0] battery_level;
  logic [7:0] voltage;
  logic       fault_clear;
  logic       charge_en;
  logic [1:0] current_sel;
  logic [2:0] phase;
  logic       done;
  logic       fault;
  logic [1:0] fault_code;
  logic       phase_change;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  charge_phase_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .charger_present (charger_present),
    .battery_level   (battery_level),
    .voltage         (voltage),
    .fault_clear     (fault_clear),
    .charge_en       (charge_en),
    .current_sel     (current_sel),
    .phase           (phase),
    .done            (done),
    .fault           (fault),
    .fault_code      (fault_code),
    .phase_change    (phase_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n edges; inputs change and outputs are sampled 1 time unit after each edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset           = 1'b1;
    charger_present = 1'b0;
    battery_level   = 8'd0;
    voltage         = 8'd0;
    fault_clear     = 1'b0;
    step(2);
    check("rst_phase", phase, 0);
    check("rst_en", charge_en, 0);
    check("rst_sel", current_sel, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_code", fault_code, 0);
    check("rst_pc", phase_change, 0);

    // Ramp from empty
    reset           = 1'b0;
    charger_present = 1'b1;
    voltage         = 8'd200;
    for (int lvl = 10; lvl <= 100; lvl++) begin
      battery_level = 8'(lvl);
      for (int k = 0; k < 8; k++) begin
        step(1);
        if (phase_change) pulses++;
        if (lvl == 10 && k == 0) begin
          check("ramp_trickle", phase, 1);
          check("ramp_trickle_sel", current_sel, 1);
        end
        if (lvl == 20 && k == 2) check("ramp_bulk_early", phase, 1);
        if (lvl == 20 && k == 3) begin
          check("ramp_bulk", phase, 2);
          check("ramp_bulk_sel", current_sel, 2);
          check("ramp_bulk_pc", phase_change, 1);
        end
        if (lvl == 80 && k == 2) check("ramp_taper_early", phase, 2);
        if (lvl == 80 && k == 3) check("ramp_taper_sel", current_sel, 3);
        if (lvl == 100 && k == 3) begin
          check("ramp_done", phase, 4);
          check("ramp_done_flag", done, 1);
          check("ramp_done_en", charge_en, 0);
        end
      end
    end
    check("ramp_pulses", pulses, 4);

    // DONE restart, then taper timeout
    battery_level = 8'd94;
    step(3);
    check("restart_hold", phase, 4);
    step(1);
    check("restart_idle", phase, 0);
    battery_level = 8'd90;
    step(1);
    check("restart_taper", phase, 3);
    step(999);
    check("timeout_pre", phase, 3);
    step(1);
    check("timeout_phase", phase, 5);
    check("timeout_code", fault_code, 3);
    check("timeout_en", charge_en, 0);
    fault_clear = 1'b1;
    step(1);
    check("timeout_clear", phase, 0);
    check("timeout_clear_code", fault_code, 0);
    fault_clear = 1'b0;
    step(1);
    check("reenter_taper", phase, 3);

    // Charger removal in TAPER
    charger_present = 1'b0;
    step(1);
    check("remove_idle", phase, 0);
    step(2);
    check("remove_stay", phase, 0);

    // Overvoltage in BULK
    charger_present = 1'b1;
    battery_level   = 8'd50;
    step(1);
    check("ov_bulk", phase, 2);
    voltage = 8'd241;
    step(1);
    voltage = 8'd200;
    check("ov_fault", phase, 5);
    check("ov_code", fault_code, 1);
    check("ov_en", charge_en, 0);
    voltage     = 8'd241;
    fault_clear = 1'b1;
    step(1);
    check("ov_clear_blocked", phase, 5);
    fault_clear   = 1'b0;
    voltage       = 8'd200;
    battery_level = 8'd101;
    step(1);
    check("ov_code_held", fault_code, 1);
    battery_level = 8'd50;
    fault_clear   = 1'b1;
    step(1);
    check("ov_clear", phase, 0);
    check("ov_clear_fault", fault, 0);
    fault_clear = 1'b0;

    // Glitch rejection in TRICKLE
    battery_level = 8'd10;
    step(1);
    check("glitch_trickle", phase, 1);
    battery_level = 8'd20;
    step(3);
    check("glitch_run3", phase, 1);
    battery_level = 8'd19;
    step(1);
    check("glitch_dip", phase, 1);
    battery_level = 8'd20;
    step(3);
    check("glitch_requal", phase, 1);
    step(1);
    check("glitch_bulk", phase, 2);

    // fault_clear outside FAULT has no effect
    fault_clear = 1'b1;
    step(1);
    check("clear_ignored", phase, 2);
    fault_clear = 1'b0;

    // Jump across thresholds: one step per edge, each requalified
    battery_level = 8'd100;
    step(3);
    check("jump_bulk_hold", phase, 2);
    step(1);
    check("jump_taper", phase, 3);
    step(3);
    check("jump_taper_hold", phase, 3);
    step(1);
    check("jump_done", phase, 4);

    // Reset mid-TAPER
    battery_level = 8'd85;
    step(5);
    check("pre_reset_taper", phase, 3);
    reset = 1'b1;
    step(1);
    check("midrst_phase", phase, 0);
    check("midrst_en", charge_en, 0);
    check("midrst_sel", current_sel, 0);
    check("midrst_pc", phase_change, 0);

    // Simultaneous overvoltage and overlevel
    reset         = 1'b0;
    battery_level = 8'd101;
    voltage       = 8'd250;
    step(1);
    check("dual_phase", phase, 5);
    check("dual_code", fault_code, 1);

    // Fault together with charger removal
    battery_level = 8'd50;
    voltage       = 8'd200;
    fault_clear   = 1'b1;
    step(1);
    check("dual_clear", phase, 0);
    fault_clear = 1'b0;
    step(1);
    check("rm_bulk", phase, 2);
    charger_present = 1'b0;
    voltage         = 8'd250;
    step(1);
    check("rm_fault", phase, 5);
    check("rm_code", fault_code, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
